mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester (I) and the load/store requester (D).
- Sits between the fetch/LSU stages of the microprocessor and the unified memory.
- Allows one outstanding memory transaction at a time. D has priority, with a starvation guard for I and a response timeout that returns an error.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables are DATA_W/8 bits)
TIMEOUT, 16, max BUSY cycles waiting for m_rvalid before an error response (>=2)
MAX_STREAK, 4, consecutive D grants allowed while I waits before I is forced (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
i_req  in  1  fetch request, held until i_gnt
i_addr  in  ADDR_W  fetch address
i_gnt  out  1  fetch accepted (1-cycle pulse)
i_rvalid  out  1  fetch response valid (1-cycle pulse)
i_rdata  out  DATA_W  fetch data
i_err  out  1  fetch timed out (qualified by i_rvalid)
d_req  in  1  load/store request, held until d_gnt
d_we  in  1  1 = store
d_be  in  DATA_W/8  byte enables
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data accepted (1-cycle pulse)
d_rvalid  out  1  data response or store ack (1-cycle pulse)
d_rdata  out  DATA_W  load data
d_err  out  1  data timed out (qualified by d_rvalid)
m_req  out  1  memory request (1-cycle pulse)
m_we  out  1  memory write enable
m_be  out  DATA_W/8  memory byte enables
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rvalid  in  1  memory response/ack
m_rdata  in  DATA_W  memory read data

Behaviour:
- Reset:
  - rst is sampled on the rising edge of clk.
  - State returns to IDLE; the timeout counter, the streak counter and the owner register clear.
  - While rst is high, every output is 0.
  - Reset mid-transaction abandons the transaction: no rvalid is issued, and a later m_rvalid is ignored.
- States:
  - IDLE: no transaction outstanding.
  - BUSY_I: a fetch is outstanding.
  - BUSY_D: a data access is outstanding.
- IDLE with any request:
  - Same cycle (combinational): m_req=1; m_addr/m_we/m_be/m_wdata driven from the winner; winner's gnt=1.
  - Next state is BUSY_<winner>; the timeout counter loads 0.
  - For I grants: m_we=0, m_be all ones, m_wdata=0.
  - When m_req=0, the m_* payload outputs are 0.
- Arbitration in IDLE:
  - Only one requester active: it wins.
  - Both requesting: D wins unless streak==MAX_STREAK, in which case I wins.
- Streak counter:
  - Increments on a D grant while i_req=1.
  - Clears on any I grant, or on a D grant while i_req=0.
  - Saturates at MAX_STREAK.
- BUSY_x with m_rvalid=1:
  - Same cycle: x_rvalid=1, x_rdata=m_rdata, x_err=0; next state IDLE.
  - A store ack also passes m_rdata through; its value is don't-care.
- BUSY_x without m_rvalid:
  - Counter increments.
  - When the counter==TIMEOUT-1 and m_rvalid=0: x_rvalid=1, x_err=1, x_rdata=0; next state IDLE.
  - Net effect: the error pulse is the TIMEOUT-th BUSY cycle.
- m_rvalid in IDLE is ignored and produces no output.
- Non-owner outputs: rvalid/rdata/err of the requester that does not own the transaction are always 0.
- No grant is issued in BUSY states. The minimum request-to-request spacing is 2 cycles (grant, response), and a new grant can come at the earliest the cycle after the response.
- Latency: grant is 0 cycles after req in IDLE. Response is the same cycle as m_rvalid.

Test Plan:
- Reset & idle: rst=1 for 2 cycles with i_req=d_req=1 -> all outputs 0. Release rst with i_req=0, d_req=0 -> m_req stays 0.
- Single fetch: i_req=1, i_addr=0x100 in IDLE -> same cycle i_gnt=1, m_req=1, m_addr=0x100, m_we=0, m_be=0xF. Memory returns m_rvalid with 0xDEADBEEF 3 cycles later -> i_rvalid=1, i_rdata=0xDEADBEEF, i_err=0 that cycle, d_rvalid=0.
- Store: d_req=1, d_we=1, d_be=0x3, d_addr=0x200, d_wdata=0x1234 -> d_gnt=1 and m_* match. Ack after 1 cycle -> d_rvalid=1, d_err=0.
- Priority & starvation: i_req and d_req held high continuously, memory acks in 1 cycle, MAX_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I. Each grant is followed 2 cycles later by the next grant.
- Timeout: fetch granted, memory never responds, TIMEOUT=16 -> i_rvalid=1, i_err=1, i_rdata=0 on the 16th BUSY cycle. State returns to IDLE. A late m_rvalid in IDLE produces no rvalid.
- Reset mid-op: D granted, rst asserted for 1 cycle before m_rvalid, then m_rvalid arrives -> no d_rvalid. The next i_req is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D).
// One outstanding transaction; D has priority with a streak guard for I, plus response timeout.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 16,
  parameter int MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                m_req,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int STK_W = $clog2(MAX_STREAK + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_STREAK);

  // The busy state doubles as the owner of the outstanding transaction.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STK_W-1:0] streak_q, streak_d;
  logic             pick_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    streak_d = streak_q;
    pick_i   = 1'b0;
    i_gnt    = 1'b0;
    i_rvalid = 1'b0;
    i_rdata  = '0;
    i_err    = 1'b0;
    d_gnt    = 1'b0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    d_err    = 1'b0;
    m_req    = 1'b0;
    m_we     = 1'b0;
    m_be     = '0;
    m_addr   = '0;
    m_wdata  = '0;

    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            pick_i = i_req && (!d_req || (streak_q == STK_MAX));
            m_req  = 1'b1;
            cnt_d  = '0;
            if (pick_i) begin
              i_gnt    = 1'b1;
              m_be     = '1;
              m_addr   = i_addr;
              streak_d = '0;
              state_d  = BUSY_I;
            end else begin
              d_gnt   = 1'b1;
              m_we    = d_we;
              m_be    = d_be;
              m_addr  = d_addr;
              m_wdata = d_wdata;
              state_d = BUSY_D;
              // Only D wins over a waiting I, so the streak counts I's wait.
              if (!i_req)
                streak_d = '0;
              else if (streak_q != STK_MAX)
                streak_d = streak_q + 1'b1;
            end
          end
        end
        BUSY_I: begin
          if (m_rvalid) begin
            i_rvalid = 1'b1;
            i_rdata  = m_rdata;
            state_d  = IDLE;
          end else if (cnt_q == CNT_LAST) begin
            i_rvalid = 1'b1;
            i_err    = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        BUSY_D: begin
          if (m_rvalid) begin
            d_rvalid = 1'b1;
            d_rdata  = m_rdata;
            state_d  = IDLE;
          end else if (cnt_q == CNT_LAST) begin
            d_rvalid = 1'b1;
            d_err    = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, store, priority/starvation, timeout, mid-op reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .MAX_STREAK(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected grant order with both requesters held: 1 = I, 0 = D.
  logic [9:0] order_i;

  initial begin
    order_i = 10'b1000010000; // bit k = grant k (LSB first): D,D,D,D,I,D,D,D,D,I
    rst = 1'b1; i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b1;
    d_be = 4'hF; d_addr = 32'h20; d_wdata = 32'h55; m_rvalid = 1'b1; m_rdata = 32'h99;

    // Reset with all inputs active
    cyc();
    check("rst_m_req", m_req, 0);
    check("rst_gnts", {i_gnt, d_gnt}, 0);
    check("rst_rvalids", {i_rvalid, d_rvalid, i_err, d_err}, 0);
    check("rst_m_payload", {m_we, m_be, m_addr, m_wdata} != 0, 0);
    cyc();
    check("rst_rdata", {i_rdata, d_rdata}, 0);
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; m_rvalid = 1'b0; d_we = 1'b0;
    #1;
    check("idle_m_req", m_req, 0);
    cyc();
    check("idle_m_req2", m_req, 0);

    // Single fetch, response 3 cycles later
    i_req = 1'b1; i_addr = 32'h100; #1;
    check("fetch_i_gnt", i_gnt, 1);
    check("fetch_m_req", m_req, 1);
    check("fetch_m_addr", m_addr, 32'h100);
    check("fetch_m_we_be_wd", {m_we, m_be, m_wdata}, {1'b0, 4'hF, 32'h0});
    check("fetch_d_gnt", d_gnt, 0);
    cyc(); i_req = 1'b0; #1;
    check("fetch_wait1", {i_rvalid, m_req, i_gnt}, 0);
    cyc();
    check("fetch_wait2", i_rvalid, 0);
    cyc(); m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; #1;
    check("fetch_i_rvalid", i_rvalid, 1);
    check("fetch_i_rdata", i_rdata, 32'hDEADBEEF);
    check("fetch_i_err", i_err, 0);
    check("fetch_d_side", {d_rvalid, d_rdata}, 0);
    cyc(); m_rvalid = 1'b0; #1;
    check("fetch_after", i_rvalid, 0);

    // Store with ack after 1 cycle
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h200; d_wdata = 32'h1234; #1;
    check("store_d_gnt", {d_gnt, i_gnt, m_req}, 3'b101);
    check("store_m_pay", {m_we, m_be, m_addr, m_wdata}, {1'b1, 4'h3, 32'h200, 32'h1234});
    cyc(); d_req = 1'b0; d_we = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0; #1;
    check("store_ack", {d_rvalid, d_err, i_rvalid}, 3'b100);
    cyc(); m_rvalid = 1'b0;

    // Priority and starvation guard
    i_req = 1'b1; i_addr = 32'h300; d_req = 1'b1; d_addr = 32'h400; d_be = 4'hF;
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("prio%0d_gnt", k), {i_gnt, d_gnt}, order_i[k] ? 2'b10 : 2'b01);
      check($sformatf("prio%0d_addr", k), m_addr, order_i[k] ? 32'h300 : 32'h400);
      cyc(); m_rvalid = 1'b1; m_rdata = 32'hA000 + k;
      if (k == 9) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      #1;
      check($sformatf("prio%0d_busy", k), {i_gnt, d_gnt, m_req}, 0);
      check($sformatf("prio%0d_rv", k), {i_rvalid, d_rvalid},
            order_i[k] ? 2'b10 : 2'b01);
      cyc(); m_rvalid = 1'b0;
    end

    // Timeout: error pulse on the 16th busy cycle
    i_req = 1'b1; i_addr = 32'h500; m_rdata = 32'hFFFFFFFF; #1;
    check("to_i_gnt", i_gnt, 1);
    cyc(); i_req = 1'b0;
    for (int n = 1; n < 16; n++) begin
      #1;
      check($sformatf("to_wait%0d", n), {i_rvalid, d_rvalid}, 0);
      cyc();
    end
    #1;
    check("to_i_rvalid", i_rvalid, 1);
    check("to_i_err", i_err, 1);
    check("to_i_rdata", i_rdata, 0);
    check("to_d_side", {d_rvalid, d_err}, 0);
    cyc(); m_rvalid = 1'b1; #1;
    check("to_late_rvalid", {i_rvalid, d_rvalid, m_req}, 0);
    cyc(); m_rvalid = 1'b0;

    // Reset in the middle of a data access
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; #1;
    check("mid_d_gnt", d_gnt, 1);
    cyc(); d_req = 1'b0; rst = 1'b1; #1;
    check("mid_rst_out", {d_rvalid, m_req}, 0);
    cyc(); rst = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h77; #1;
    check("mid_no_rvalid", {d_rvalid, i_rvalid}, 0);
    cyc(); m_rvalid = 1'b0; i_req = 1'b1; i_addr = 32'h700; #1;
    check("mid_i_gnt", {i_gnt, m_req}, 2'b11);
    check("mid_i_addr", m_addr, 32'h700);
    cyc(); i_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D; #1;
    check("mid_i_rvalid", i_rvalid, 1);
    check("mid_i_rdata", i_rdata, 32'hCAFEF00D);
    cyc(); m_rvalid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
